instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Fetch stage directly upstream of the instruction memory in the RISC-V core.
- Owns the program counter and drives the 8-bit byte address into the combinational instruction ROM.
- Captures the returned 32-bit word, with its PC and PC+4, into an IF/ID register for the decoder.
- Handles stall, branch/jump redirect with flush, misaligned-target detection and a fetched-instruction counter.

Parameters:
- ADDR_W, 8, PC/instruction-memory byte address width.
- RESET_PC, 8'h00, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, addi x0,x0,0 placed in the IF/ID register when it is empty or flushed.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold PC and IF/ID (load-use or back-pressure from decode).
- redirect_i  in  1  taken branch/jump from execute.
- redirect_pc_i  in  ADDR_W  branch/jump target byte address.
- imem_addr_o  out  ADDR_W  address to instruction memory A.
- imem_rd_i  in  32  instruction word from instruction memory RD, valid in the same cycle.
- if_instr_o  out  32  registered instruction.
- if_pc_o  out  ADDR_W  registered PC of if_instr_o.
- if_pc4_o  out  ADDR_W  registered PC+4, modulo 2^ADDR_W.
- if_valid_o  out  1  IF/ID holds a real instruction.
- misalign_o  out  1  one-cycle pulse: redirect target had bits [1:0] != 0.
- fetch_cnt_o  out  CNT_W  count of instructions captured with valid=1; saturating.

Behaviour:

Reset (asynchronous, immediate, any time including mid-redirect or mid-stall):
- pc = RESET_PC
- if_instr_o = NOP_INSTR
- if_pc_o = 0, if_pc4_o = 0
- if_valid_o = 0, misalign_o = 0, fetch_cnt_o = 0

Address path:
- imem_addr_o = pc, combinational from the PC register.
- The ROM is combinational, so the fetch latency is 0 cycles to the word and 1 clock edge to the IF/ID register.

Per rising edge, priority redirect > stall > normal:
- **Redirect:**
  - pc <= {redirect_pc_i[7:2], 2'b00}; the target is forced word-aligned.
  - IF/ID flushed: if_instr_o <= NOP_INSTR, if_valid_o <= 0; if_pc_o and if_pc4_o hold.
  - misalign_o <= |redirect_pc_i[1:0].
  - Counter unchanged.
  - A redirect asserted together with stall_i still redirects and flushes; the stall is ignored that cycle.
- **Stall (redirect_i = 0):**
  - pc, if_instr_o, if_pc_o, if_pc4_o, if_valid_o and fetch_cnt_o all hold.
  - misalign_o <= 0.
- **Normal:**
  - if_instr_o <= imem_rd_i, if_pc_o <= pc, if_pc4_o <= pc+4, if_valid_o <= 1.
  - pc <= pc+4.
  - fetch_cnt_o <= fetch_cnt_o+1, saturating at 2^CNT_W-1 (stays at all-ones).
  - misalign_o <= 0.

Boundary cases:
- Wrap-around: pc 8'hFC + 4 = 8'h00; no flag is raised and if_pc4_o = 8'h00.
- Redirect to the current pc (self-loop, e.g. beq x0,x0,0) is legal. The stage fetches the same word again; the slot after each redirect is always a flushed bubble.
- Back-to-back redirects: each flushes, and the last target wins.
- X-safety: no output may depend on imem_rd_i while stalled or redirecting.

Single always_ff FSM-free datapath; the states are implicit in the {valid, pc} registers.

Decomposition:
- Package riscv_core_pkg holds:
  - ADDR_W, RESET_PC, NOP_INSTR, CNT_W.
  - typedef if_id_t as a packed struct {instr[31:0], pc, pc4, valid}, shared with the decode stage.
- One sub-module, if_id_reg, holds the IF/ID register with hold/flush/load controls. It is instantiated once and reused later by the pipelined core.
- PC, next-PC mux and counter stay in instr_fetch.

Test Plan:
1. Reset release with ROM returning 32'h00100193 at addr 00 and 32'h0ff00083 at 04:
   - After edge 1: if_instr_o = 00100193, if_pc_o = 00, if_pc4_o = 04, imem_addr_o = 04, valid = 1, fetch_cnt_o = 1.
   - After edge 2: if_instr_o = 0ff00083.
2. stall_i high for 3 cycles at pc = 08 -> imem_addr_o stays 08, all IF/ID outputs and fetch_cnt_o frozen. After release, the next edge loads the word at 08.
3. redirect_i with redirect_pc_i = 8'h20 while stall_i = 1 -> next edge: imem_addr_o = 20, if_instr_o = 00000013, valid = 0, counter unchanged. The following edge captures the word at 20 with if_pc_o = 20.
4. redirect_pc_i = 8'h1E -> pc = 8'h1C, misalign_o high for exactly one cycle, then low.
5. Run from pc = 8'hF8 -> imem_addr_o sequence F8, FC, 00. The if_pc4_o captured for FC equals 00.
6. Assert reset asynchronously mid-cycle during a redirect, and preload fetch_cnt_o near FFFF:
   - Reset: all outputs take their reset values without waiting for a clock edge.
   - Separate run from FFFE: counter goes FFFE -> FFFF -> stays FFFF.

Source files
------------

// File: rtl/riscv_core_pkg.sv
// Shared definitions for the RISC-V core pipeline front end.
// Holds the fetch-stage sizing constants and the IF/ID record type
// handed from the fetch stage to the decode stage.
package riscv_core_pkg;

  // PC / instruction-memory byte address width
  localparam int ADDR_W = 8;
  // Width of the saturating fetched-instruction counter
  localparam int CNT_W  = 16;

  localparam logic [ADDR_W-1:0] RESET_PC  = 8'h00;
  localparam logic [ADDR_W-1:0] PC_STEP   = 8'h04;
  // addi x0,x0,0 : the bubble placed in IF/ID when it is empty or flushed
  localparam logic [31:0]       NOP_INSTR = 32'h00000013;

  // IF/ID pipeline record
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic              valid;
  } if_id_t;

  localparam if_id_t IF_ID_RESET = '{
    instr: NOP_INSTR,
    pc:    8'h00,
    pc4:   8'h00,
    valid: 1'b0
  };

  // Force a byte address onto a word boundary
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register with flush/hold/load control.
// Priority: flush > hold > load. A flush turns the slot into a NOP
// bubble but keeps the last pc/pc4 so downstream debug still sees
// where the bubble came from.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   hold      : keep current contents
//   flush     : replace instruction by NOP and clear valid
//   d         : record loaded when neither hold nor flush
//   q         : registered record
module if_id_reg
  import riscv_core_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t q_r;

  // IF/ID register update: flush beats hold beats load
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r <= IF_ID_RESET;
    end else if (flush) begin
      q_r.instr <= NOP_INSTR;
      q_r.valid <= 1'b0;
    end else if (hold) begin
      q_r <= q_r;
    end else begin
      q_r <= d;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage in front of a combinational instruction ROM.
// Owns the PC, presents it as the ROM address, captures the returned word
// with its PC and PC+4 into the IF/ID register, and counts fetched words.
// Priority per edge: redirect > stall > normal advance.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   stall_i               : hold PC and IF/ID
//   redirect_i            : taken branch/jump, flushes IF/ID
//   redirect_pc_i         : branch/jump target (low bits forced to 0)
//   imem_addr_o           : byte address to instruction ROM
//   imem_rd_i             : instruction word from ROM, same cycle
//   if_instr_o/pc_o/pc4_o : IF/ID contents
//   if_valid_o            : IF/ID holds a real instruction
//   misalign_o            : one-cycle pulse on a misaligned redirect target
//   fetch_cnt_o           : saturating count of valid captures
module instr_fetch
  import riscv_core_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_rd_i,
  output logic [31:0]       if_instr_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [ADDR_W-1:0] if_pc4_o,
  output logic              if_valid_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_next_s;
  logic [ADDR_W-1:0] pc_plus4_s;
  logic              advance_s;
  logic              misalign_r;
  logic [CNT_W-1:0]  cnt_r;
  if_id_t            if_id_d_s;
  if_id_t            if_id_q_s;

  // Wraps modulo 2^ADDR_W with no flag
  assign pc_plus4_s = pc_r + PC_STEP;

  // Next-PC mux; advance_s marks a normal fetch that loads IF/ID
  always_comb begin
    pc_next_s = pc_r;
    advance_s = 1'b0;
    if (redirect_i) begin
      pc_next_s = word_align(redirect_pc_i);
    end else if (stall_i) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_plus4_s;
      advance_s = 1'b1;
    end
  end

  // PC register, misalign pulse and saturating fetch counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r       <= RESET_PC;
      misalign_r <= 1'b0;
      cnt_r      <= {CNT_W{1'b0}};
    end else begin
      pc_r       <= pc_next_s;
      misalign_r <= redirect_i & (|redirect_pc_i[1:0]);
      if (advance_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  // ROM data only reaches IF/ID on a normal fetch; flush and hold ignore it
  assign if_id_d_s = '{
    instr: imem_rd_i,
    pc:    pc_r,
    pc4:   pc_plus4_s,
    valid: 1'b1
  };

  if_id_reg u_if_id_reg (
    .clk   (clk),
    .rst   (reset),
    .hold  (stall_i),
    .flush (redirect_i),
    .d     (if_id_d_s),
    .q     (if_id_q_s)
  );

  assign imem_addr_o = pc_r;
  assign if_instr_o  = if_id_q_s.instr;
  assign if_pc_o     = if_id_q_s.pc;
  assign if_pc4_o    = if_id_q_s.pc4;
  assign if_valid_o  = if_id_q_s.valid;
  assign misalign_o  = misalign_r;
  assign fetch_cnt_o = cnt_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch, plus hand-written
// sequences for asynchronous reset and counter saturation.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [7:0]  redirect_pc_i;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_rd_i;
  logic [31:0] if_instr_o;
  logic [7:0]  if_pc_o;
  logic [7:0]  if_pc4_o;
  logic        if_valid_o;
  logic        misalign_o;
  logic [15:0] fetch_cnt_o;

  int total;
  int bad;

  instr_fetch dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_rd_i     (imem_rd_i),
    .if_instr_o    (if_instr_o),
    .if_pc_o       (if_pc_o),
    .if_pc4_o      (if_pc4_o),
    .if_valid_o    (if_valid_o),
    .misalign_o    (misalign_o),
    .fetch_cnt_o   (fetch_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM model
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    if (a == 8'h00)      return 32'h00100193;
    else if (a == 8'h04) return 32'h0ff00083;
    else                 return {16'hC0DE, 8'h00, a};
  endfunction

  assign imem_rd_i = rom_word(imem_addr_o);

  typedef struct {
    logic        stall;
    logic        redir;
    logic [7:0]  rpc;
    logic [7:0]  addr;
    logic [31:0] instr;
    logic [7:0]  pc;
    logic [7:0]  pc4;
    logic        valid;
    logic        mis;
    logic [15:0] cnt;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic s, input logic r, input logic [7:0] rpc,
                              input logic [7:0] addr, input logic [31:0] instr,
                              input logic [7:0] pc, input logic [7:0] pc4,
                              input logic v, input logic m, input logic [15:0] c);
    vec_t t;
    t.stall = s; t.redir = r; t.rpc = rpc; t.addr = addr; t.instr = instr;
    t.pc = pc; t.pc4 = pc4; t.valid = v; t.mis = m; t.cnt = c;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] addr, input logic [31:0] instr,
                           input logic [7:0] pc, input logic [7:0] pc4, input logic v,
                           input logic m, input logic [15:0] c);
    check({tag, ".addr"},  {24'h0, imem_addr_o}, {24'h0, addr});
    check({tag, ".instr"}, if_instr_o, instr);
    check({tag, ".pc"},    {24'h0, if_pc_o}, {24'h0, pc});
    check({tag, ".pc4"},   {24'h0, if_pc4_o}, {24'h0, pc4});
    check({tag, ".valid"}, {31'h0, if_valid_o}, {31'h0, v});
    check({tag, ".mis"},   {31'h0, misalign_o}, {31'h0, m});
    check({tag, ".cnt"},   {16'h0, fetch_cnt_o}, {16'h0, c});
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // state after each edge, hand-computed
    vecs[0]  = mk(1'b0, 1'b0, 8'h00, 8'h04, 32'h00100193, 8'h00, 8'h04, 1'b1, 1'b0, 16'd1);
    vecs[1]  = mk(1'b0, 1'b0, 8'h00, 8'h08, 32'h0ff00083, 8'h04, 8'h08, 1'b1, 1'b0, 16'd2);
    vecs[2]  = mk(1'b1, 1'b0, 8'h00, 8'h08, 32'h0ff00083, 8'h04, 8'h08, 1'b1, 1'b0, 16'd2);
    vecs[3]  = mk(1'b1, 1'b0, 8'h00, 8'h08, 32'h0ff00083, 8'h04, 8'h08, 1'b1, 1'b0, 16'd2);
    vecs[4]  = mk(1'b1, 1'b0, 8'h00, 8'h08, 32'h0ff00083, 8'h04, 8'h08, 1'b1, 1'b0, 16'd2);
    vecs[5]  = mk(1'b0, 1'b0, 8'h00, 8'h0C, 32'hC0DE0008, 8'h08, 8'h0C, 1'b1, 1'b0, 16'd3);
    vecs[6]  = mk(1'b1, 1'b1, 8'h20, 8'h20, 32'h00000013, 8'h08, 8'h0C, 1'b0, 1'b0, 16'd3);
    vecs[7]  = mk(1'b0, 1'b0, 8'h00, 8'h24, 32'hC0DE0020, 8'h20, 8'h24, 1'b1, 1'b0, 16'd4);
    vecs[8]  = mk(1'b0, 1'b1, 8'h1E, 8'h1C, 32'h00000013, 8'h20, 8'h24, 1'b0, 1'b1, 16'd4);
    vecs[9]  = mk(1'b0, 1'b0, 8'h00, 8'h20, 32'hC0DE001C, 8'h1C, 8'h20, 1'b1, 1'b0, 16'd5);
    vecs[10] = mk(1'b0, 1'b1, 8'h20, 8'h20, 32'h00000013, 8'h1C, 8'h20, 1'b0, 1'b0, 16'd5);
    vecs[11] = mk(1'b0, 1'b0, 8'h00, 8'h24, 32'hC0DE0020, 8'h20, 8'h24, 1'b1, 1'b0, 16'd6);
    vecs[12] = mk(1'b0, 1'b1, 8'h40, 8'h40, 32'h00000013, 8'h20, 8'h24, 1'b0, 1'b0, 16'd6);
    vecs[13] = mk(1'b1, 1'b1, 8'h81, 8'h80, 32'h00000013, 8'h20, 8'h24, 1'b0, 1'b1, 16'd6);
    vecs[14] = mk(1'b0, 1'b1, 8'hF8, 8'hF8, 32'h00000013, 8'h20, 8'h24, 1'b0, 1'b0, 16'd6);
    vecs[15] = mk(1'b0, 1'b0, 8'h00, 8'hFC, 32'hC0DE00F8, 8'hF8, 8'hFC, 1'b1, 1'b0, 16'd7);
    vecs[16] = mk(1'b0, 1'b0, 8'h00, 8'h00, 32'hC0DE00FC, 8'hFC, 8'h00, 1'b1, 1'b0, 16'd8);
    vecs[17] = mk(1'b0, 1'b0, 8'h00, 8'h04, 32'h00100193, 8'h00, 8'h04, 1'b1, 1'b0, 16'd9);

    reset = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 8'h00;
    #1;
    check_all("reset", 8'h00, 32'h00000013, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      stall_i       = vecs[i].stall;
      redirect_i    = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc;
      @(posedge clk);
      #1;
      check_all($sformatf("v%0d", i), vecs[i].addr, vecs[i].instr, vecs[i].pc,
                vecs[i].pc4, vecs[i].valid, vecs[i].mis, vecs[i].cnt);
      @(negedge clk);
    end

    // asynchronous reset in the middle of a redirect cycle
    stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 8'h33;
    #2;
    reset = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 32'h00000013, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
    @(posedge clk);
    #1;
    check_all("rst_held", 8'h00, 32'h00000013, 8'h00, 8'h00, 1'b0, 1'b0, 16'd0);
    @(negedge clk);
    redirect_i = 1'b0; redirect_pc_i = 8'h00;
    reset = 1'b0;

    // saturation: 65534 fetches bring the counter to FFFE
    repeat (65534) @(posedge clk);
    #1;
    check("cnt_fffe", {16'h0, fetch_cnt_o}, 32'h0000FFFE);
    @(posedge clk);
    #1;
    check("cnt_ffff", {16'h0, fetch_cnt_o}, 32'h0000FFFF);
    @(posedge clk);
    #1;
    check("cnt_sat", {16'h0, fetch_cnt_o}, 32'h0000FFFF);
    check("sat_valid", {31'h0, if_valid_o}, 32'h00000001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
